// File: rtl/accum_feeder.sv
// accum_feeder: a small FIFO that buffers upstream words, plus a burst
// controller that pops Len words, one per cycle, into a downstream
// accumulator and then pulses done.
module accum_feeder #(
    parameter int N     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         start,
    input  logic [3:0]   len,
    output logic         en,
    output logic [N-1:0] data,
    output logic         busy,
    output logic         done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [N-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [3:0]      remaining;

    logic            push;
    logic            pop;
    logic            start_burst;
    logic            start_empty;

    // Full blocks the upstream even when a pop happens on the same edge,
    // and nothing is accepted while reset is held.
    assign in_ready    = (count != CW'(DEPTH)) && !reset;
    assign push        = in_valid && in_ready;
    // Pop only what was already stored before this edge: no write-to-read bypass.
    assign pop         = (state == S_FEED) && (count != '0);
    assign start_burst = (state == S_IDLE) && start && (len != 4'd0);
    assign start_empty = (state == S_IDLE) && start && (len == 4'd0);
    assign busy        = (state == S_FEED);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            state <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        // NOTE: default first, so no path through this block leaves
        // state_next unassigned and a latch cannot be inferred.
        state_next = state;
        unique case (state)
            S_IDLE: if (start_burst)                       state_next = S_FEED;
            S_FEED: if (pop && (remaining == 4'd1))        state_next = S_DONE;
            S_DONE:                                        state_next = S_IDLE;
            default:                                       state_next = S_IDLE;
        endcase
    end

    // FIFO storage; only written on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately left out of reset; the pointers and
        // counter define which entries are valid, so stale contents are harmless.
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; push and pop are independent of the FSM
    // state, and a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Burst counter: loaded when a non-empty burst starts, counts pops down;
    // a stall in FEED leaves it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= 4'd0;
        end else if (start_burst) begin
            remaining <= len;
        end else if (pop) begin
            remaining <= remaining - 4'd1;
        end
    end

    // Registered accumulator interface. The done pulse is registered from
    // the DONE state (or from a zero-length start), so it appears in the
    // cycle after the last en pulse instead of overlapping it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en   <= 1'b0;
            data <= '0;
            done <= 1'b0;
        end else begin
            en   <= pop;
            if (pop) begin
                data <= mem[rd_ptr];
            end
            done <= (state == S_DONE) || start_empty;
        end
    end

endmodule

// File: tb/tb_accum_feeder.sv
// tb_accum_feeder: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based behavioural model of the feeder.
module tb_accum_feeder;

    localparam int N     = 6;
    localparam int DEPTH = 4;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_data  = '0;
    logic         start    = 1'b0;
    logic [3:0]   len      = 4'd0;
    logic         in_ready;
    logic         en;
    logic [N-1:0] data;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    accum_feeder #(.N(N), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .start    (start),
        .len      (len),
        .en       (en),
        .data     (data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = waiting for a start, 1 = feeding a burst, 2 = burst finished
    logic [N-1:0] m_q [$];
    int           m_mode   = 0;
    int           m_left   = 0;
    logic         m_en     = 1'b0;
    logic [N-1:0] m_data   = '0;
    logic         m_done   = 1'b0;

    // Model update: every decision uses the pre-edge FIFO contents and mode.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_mode = 0;
            m_left = 0;
            m_en   = 1'b0;
            m_data = '0;
            m_done = 1'b0;
        end else begin
            bit do_push;
            bit do_pop;
            int old_mode;
            old_mode = m_mode;
            do_push  = in_valid && (m_q.size() < DEPTH);
            do_pop   = (old_mode == 1) && (m_q.size() > 0);
            m_en     = do_pop;
            m_done   = (old_mode == 2) || (old_mode == 0 && start && len == 4'd0);
            if (do_pop) begin
                m_data = m_q.pop_front();
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 2;
            end else if (old_mode == 2) begin
                m_mode = 0;
            end else if (old_mode == 0 && start && len != 4'd0) begin
                m_mode = 1;
                m_left = int'(len);
            end
            if (do_push) m_q.push_back(in_data);
        end
    end

    // ---------------- per-cycle compare and observation log ----------------
    logic [N-1:0] out_log [$];
    int           en_cnt   = 0;
    int           done_cnt = 0;
    int           busy_cnt = 0;

    always @(negedge clk) begin
        check("in_ready", in_ready, !reset && (m_q.size() < DEPTH));
        check("en",       en,       m_en);
        check("data",     data,     m_data);
        check("busy",     busy,     (m_mode == 1));
        check("done",     done,     m_done);
        if (en) begin
            out_log.push_back(data);
            en_cnt++;
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        out_log.delete();
        en_cnt   = 0;
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("rst_en",       en,       1'b0);
        check("rst_data",     data,     '0);
        check("rst_busy",     busy,     1'b0);
        check("rst_done",     done,     1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        step();
        reset = 1'b0;
        step();
        clear_log();
    endtask

    task automatic push(input logic [N-1:0] d);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!taken) check("push_timeout", 0, 1);
    endtask

    task automatic start_burst(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        step();
        check("done_seen", seen, 1'b1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [N-1:0] acc;
        int           accepted;

        do_reset();

        // Push 2,4,7 then a Len=3 burst; downstream 6-bit accumulator sums to 13.
        push(6'd2); push(6'd4); push(6'd7);
        start_burst(4'd3);
        wait_done(50);
        check("b3_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check("b3_w0", out_log[0], 2);
            check("b3_w1", out_log[1], 4);
            check("b3_w2", out_log[2], 7);
        end
        acc = '0;
        foreach (out_log[i]) acc = acc + out_log[i];
        check("b3_acc", acc, 13);
        check("b3_busy_cycles", busy_cnt, 3);

        // Back-to-back 1..5 with no start: only 4 fit, upstream holds the 5th.
        clear_log();
        accepted = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data = N'(accepted + 1);
            @(negedge clk);
            if (in_ready) accepted++;
            step();
        end
        in_valid = 1'b0;
        check("full_accepted", accepted, 4);
        @(negedge clk);
        check("full_in_ready", in_ready, 1'b0);
        step();
        start_burst(4'd5);
        push(6'd5);
        wait_done(50);
        check("full_count", out_log.size(), 5);
        foreach (out_log[i]) check("full_order", out_log[i], i + 1);

        // Zero-length start: one done pulse, no en, never busy.
        clear_log();
        start_burst(4'd0);
        repeat (4) step();
        check("len0_done", done_cnt, 1);
        check("len0_en",   en_cnt,   0);
        check("len0_busy", busy_cnt, 0);

        // Len=2 on an empty FIFO with late pushes: stalls, busy throughout.
        clear_log();
        start_burst(4'd2);
        repeat (2) step();
        push(6'd9);
        step();
        push(6'd3);
        wait_done(50);
        check("stall_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("stall_w0", out_log[0], 9);
            check("stall_w1", out_log[1], 3);
        end
        check("stall_busy_gt_en", busy_cnt > en_cnt, 1);

        // Reset after the first word of a Len=3 burst aborts with no done.
        clear_log();
        push(6'd21); push(6'd22); push(6'd23);
        start_burst(4'd3);
        for (int i = 0; i < 20 && en_cnt == 0; i++) step();
        check("abort_first", en_cnt, 1);
        do_reset();
        repeat (3) step();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_en",   en_cnt,   0);
        start_burst(4'd1);
        push(6'd11);
        wait_done(50);
        check("abort_fresh_count", out_log.size(), 1);
        if (out_log.size() == 1) check("abort_fresh_word", out_log[0], 11);

        // Len=8 burst drained while 8 words stream in: pointer wrap, order kept.
        clear_log();
        start_burst(4'd8);
        for (int k = 0; k < 8; k++) push(N'(40 + k));
        wait_done(80);
        check("wrap_count", out_log.size(), 8);
        foreach (out_log[i]) check("wrap_order", out_log[i], 40 + i);

        // Randomized traffic, checked only by the per-cycle model compare.
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = N'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            len      = 4'($urandom_range(0, 7));
            reset    = ($urandom_range(0, 499) == 0);
            step();
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
